// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and mult/div stalls,
// branch flush steering and a saturating stall-cycle counter.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_md_start,
  input  logic        ID_md_div,
  input  logic        ID_hilo_rd,
  input  logic [4:0]  EXE_TargetReg,
  input  logic        EXE_RegWrite,
  input  logic        EXE_M2Reg,
  input  logic [4:0]  MEM_TargetReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_M2Reg,
  input  logic        EXE_flush,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        de_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W     = 6;
  localparam int unsigned STALL_W   = 16;
  localparam logic [CNT_W-1:0] DIV_CYCLES  = CNT_W'(32);
  localparam logic [CNT_W-1:0] MULT_CYCLES = CNT_W'(4);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t           state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                md_done_next;
  logic [STALL_W-1:0]  stall_cycles_next;

  logic act_rs, act_rt, load_use, md_stall, stall;

  // Operand source select; the EXE ALU result wins over anything in MEM.
  function automatic logic [1:0] fwd_sel(input logic       act,
                                         input logic [4:0] src,
                                         input logic       exe_wr,
                                         input logic       exe_ld,
                                         input logic [4:0] exe_tgt,
                                         input logic       mem_wr,
                                         input logic       mem_ld,
                                         input logic [4:0] mem_tgt);
    logic [1:0] sel;
    sel = 2'b00;
    if (act && exe_wr && !exe_ld && exe_tgt == src)
      sel = 2'b01;
    else if (act && mem_wr && mem_tgt == src)
      sel = mem_ld ? 2'b11 : 2'b10;
    return sel;
  endfunction

  always_comb begin
    act_rs   = ID_use_rs && (ID_rs != 5'd0);
    act_rt   = ID_use_rt && (ID_rt != 5'd0);
    load_use = EXE_RegWrite && EXE_M2Reg &&
               ((act_rs && EXE_TargetReg == ID_rs) || (act_rt && EXE_TargetReg == ID_rt));
    md_busy  = (state == BUSY);
    md_stall = md_busy && (ID_md_start || ID_hilo_rd);
    stall    = (load_use || md_stall) && !EXE_flush;
    fwd_a    = fwd_sel(act_rs, ID_rs, EXE_RegWrite, EXE_M2Reg, EXE_TargetReg,
                       MEM_RegWrite, MEM_M2Reg, MEM_TargetReg);
    fwd_b    = fwd_sel(act_rt, ID_rt, EXE_RegWrite, EXE_M2Reg, EXE_TargetReg,
                       MEM_RegWrite, MEM_M2Reg, MEM_TargetReg);
  end

  // Pipeline register control; a flush overrides any stall.
  always_comb begin
    pc_wen     = 1'b1;
    ifid_wen   = 1'b1;
    ifid_flush = 1'b0;
    de_bubble  = 1'b0;
    if (EXE_flush) begin
      ifid_flush = 1'b1;
      de_bubble  = 1'b1;
    end else if (stall) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      de_bubble = 1'b1;
    end
  end

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    md_done_next      = 1'b0;
    stall_cycles_next = stall_cycles;
    case (state)
      IDLE: begin
        if (ID_md_start && !stall && !EXE_flush) begin
          state_next = BUSY;
          cnt_next   = ID_md_div ? DIV_CYCLES : MULT_CYCLES;
        end
      end
      BUSY: begin
        // A flush does not stop an in-flight operation.
        if (cnt == CNT_W'(1)) begin
          state_next   = IDLE;
          cnt_next     = '0;
          md_done_next = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (stall && stall_cycles != {STALL_W{1'b1}})
      stall_cycles_next = stall_cycles + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      md_done      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      md_done      <= md_done_next;
      stall_cycles <= stall_cycles_next;
    end
  end

endmodule
